// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Generic inter-stage pipeline register with a valid/ready handshake and a
// two-entry skid buffer. in_ready and out_valid come from registered state
// only, so back-pressure never forms a combinational path between stages.
// Control bits are masked to zero whenever the stage holds no valid entry.
// A saturating counter records cycles in which the head is stalled.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous kill of all held entries
//   in_valid/in_ready   upstream handshake
//   in_ctrl/in_data     upstream control bits / payload
//   out_valid/out_ready downstream handshake
//   out_ctrl/out_data   head control bits (0 when empty) / head payload
//   occupancy           entries held (0..2)
//   stall_cnt           saturating count of out_valid & !out_ready cycles
//   stall_clr           synchronous clear of stall_cnt
module pipe_stage_skid #(
   parameter int DATA_W = 64,
   parameter int CTRL_W = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   // State encoding doubles as the occupancy count.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]        state;
   logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
   logic [DATA_W-1:0] head_data, skid_data;
   logic              in_fire, out_fire;

   assign out_valid = (state != ST_EMPTY);
   assign in_ready  = (state != ST_FULL);
   assign occupancy = state;
   assign out_ctrl  = out_valid ? head_ctrl : '0;
   assign out_data  = head_data;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_EMPTY;
         head_ctrl <= '0;
         head_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
      end else if (flush) begin
         // Any same-cycle in_fire is discarded; payload registers hold so
         // only the control bits need scrubbing.
         state     <= ST_EMPTY;
         head_ctrl <= '0;
         skid_ctrl <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  state     <= ST_ONE;
                  head_ctrl <= in_ctrl;
                  head_data <= in_data;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  head_ctrl <= in_ctrl;
                  head_data <= in_data;
               end else if (in_fire) begin
                  // Head is stalled: park the newcomer in the skid slot.
                  state     <= ST_FULL;
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
               end else if (out_fire) begin
                  state <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state     <= ST_ONE;
                  head_ctrl <= skid_ctrl;
                  head_data <= skid_data;
               end
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

   // Stall counter ignores flush; clear wins over increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_clr) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
